// File: rtl/jk_count_pkg.sv
// Shared constants and FSM encoding for the ripple-count monitor.
package jk_count_pkg;

  localparam int DEF_WIDTH         = 4;
  localparam int DEF_STABLE_CYCLES = 2;
  localparam int DEF_LOCK_MATCHES  = 2;
  localparam int DEF_ERR_W         = 8;

  // Run counter holds up to 15, match counter up to 7.
  localparam int RUN_W   = 4;
  localparam int MATCH_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2
  } mon_state_e;

endpackage

// File: rtl/count_sync_filter.sv
// Brings the raw ripple count into the clk domain and accepts a value only
// once it has been seen unchanged for STABLE_CYCLES consecutive samples.
module count_sync_filter
  import jk_count_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] count_in,
  output logic             accept,
  output logic [0:WIDTH-1] acc_value,
  output logic [0:WIDTH-1] cur_value
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
  localparam logic [RUN_W-1:0] RUN_HIT = RUN_W'(STABLE_CYCLES - 1);

  logic [0:WIDTH-1] sync1, sync2, prev;
  logic [RUN_W-1:0] run;
  logic             acc_vld;
  logic             same;

  // Multi-bit skew is not handshaken per bit; the run filter absorbs it.
  assign same      = (sync2 == prev);
  assign acc_value = sync2;
  // One-cycle event: the run just reached the window and the value is new
  // (or nothing has been accepted since reset).
  assign accept    = same && (run == RUN_HIT) &&
                     ((sync2 != cur_value) || !acc_vld);

  // Two-flop synchronizer on the whole bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= count_in;
      sync2 <= sync1;
    end
  end

  // Saturating run length of identical synchronized samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= '0;
      run  <= '0;
    end else begin
      prev <= sync2;
      if (!same)               run <= '0;
      else if (run != RUN_MAX) run <= run + RUN_W'(1);
    end
  end

  // Accepted value register and its valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_value <= '0;
      acc_vld   <= 1'b0;
    end else if (accept) begin
      cur_value <= sync2;
      acc_vld   <= 1'b1;
    end
  end

endmodule

// File: rtl/jk_count_monitor.sv
// Monitors a ripple counter bus: filters it, checks the +1 mod 2^WIDTH
// sequence, and reports lock, wrap, sequence errors and an error count.
module jk_count_monitor
  import jk_count_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int LOCK_MATCHES  = DEF_LOCK_MATCHES,
  parameter int ERR_W         = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] count_in,
  input  logic             enable,
  input  logic             err_clr,
  output logic [0:WIDTH-1] cur_value,
  output logic             locked,
  output logic             wrap_pulse,
  output logic             seq_error,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_MATCHES);
  localparam logic [0:WIDTH-1]   ONE        = WIDTH'(1);

  logic               accept;
  logic [0:WIDTH-1]   acc_value;
  mon_state_e         state, state_nxt;
  logic [0:WIDTH-1]   expected, expected_nxt;
  logic [MATCH_W-1:0] match, match_nxt;
  logic               seeded, seeded_nxt;
  logic               wrap_nxt, serr_nxt;

  count_sync_filter #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .accept    (accept),
    .acc_value (acc_value),
    .cur_value (cur_value)
  );

  // Next-state and pulse decode. 'seeded' marks that expected holds a real
  // prediction; it is cleared only when ACQUIRE is entered from IDLE, so a
  // TRACK error (which itself seeds expected) can relock straight away.
  always_comb begin
    state_nxt    = state;
    expected_nxt = expected;
    match_nxt    = match;
    seeded_nxt   = seeded;
    wrap_nxt     = 1'b0;
    serr_nxt     = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt  = ST_ACQUIRE;
          match_nxt  = '0;
          seeded_nxt = 1'b0;
        end
        ST_ACQUIRE: begin
          if (accept) begin
            expected_nxt = acc_value + ONE;
            seeded_nxt   = 1'b1;
            if (seeded && (acc_value == expected)) begin
              match_nxt = match + MATCH_W'(1);
              if (match_nxt == MATCH_LOCK) state_nxt = ST_TRACK;
            end else begin
              match_nxt = '0;
            end
          end
        end
        ST_TRACK: begin
          if (accept) begin
            expected_nxt = acc_value + ONE;
            if (acc_value == expected) begin
              wrap_nxt = (acc_value == '0);
            end else begin
              serr_nxt  = 1'b1;
              match_nxt = '0;
              state_nxt = ST_ACQUIRE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state and prediction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      expected <= '0;
      match    <= '0;
      seeded   <= 1'b0;
    end else begin
      state    <= state_nxt;
      expected <= expected_nxt;
      match    <= match_nxt;
      seeded   <= seeded_nxt;
    end
  end

  // Registered status outputs and pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      seq_error  <= 1'b0;
    end else begin
      locked     <= (state_nxt == ST_TRACK);
      wrap_pulse <= wrap_nxt;
      seq_error  <= serr_nxt;
    end
  end

  // Saturating error counter; a clear beats a coincident error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              err_count <= '0;
    else if (err_clr)                     err_count <= '0;
    else if (serr_nxt && (err_count != '1)) err_count <= err_count + ERR_W'(1);
  end

endmodule
